seg_disp_sched: RTL and testbench

SEG_DISP_SCHED -- requirements
Module: seg_disp_sched

---
 rtl/seg_disp_sched.sv | 194 +++++++++++++++++++
 tb/tb_seg_disp_sched.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_disp_sched.sv
// Refresh scheduler for an 8-digit serial seven-segment display chain.
// Arbitrates three requesters, builds a 64-bit active-low frame and shifts it out MSB first.
module seg_disp_sched #(
  parameter int unsigned DIV = 2,
  localparam int unsigned NREQ = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [NREQ-1:0] req,
  input  logic [31:0]     hex0,
  input  logic [31:0]     hex1,
  input  logic [31:0]     hex2,
  input  logic [7:0]      dp,
  output logic [NREQ-1:0] grant,
  output logic            busy,
  output logic            done,
  output logic            seg_clk,
  output logic            seg_clrn,
  output logic            seg_sout,
  output logic            SEG_PEN
);

  localparam int unsigned FRAME_W = 64;
  localparam int unsigned BIT_W   = 6;
  localparam int unsigned DIV_W   = 8;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} state_e;

  state_e               state_q, state_d;
  logic [NREQ-1:0]      grant_q, grant_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 seg_clk_q, seg_clk_d;
  logic                 sout_q, sout_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pen_q, pen_d;
  logic                 pending_q, pending_d;

  logic [NREQ-1:0]      arb_grant;
  logic [31:0]          arb_hex;
  logic [FRAME_W-1:0]   arb_frame;
  logic [BIT_W-1:0]     bit_nxt;

  // Active-low {g,f,e,d,c,b,a} glyph for one hex digit
  function automatic logic [6:0] glyph(input logic [3:0] h);
    logic [6:0] g;
    case (h)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h10;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  // Fixed-priority arbitration and frame build; a blank frame is all ones
  always_comb begin
    arb_grant = '0;
    arb_hex   = hex0;
    arb_frame = '1;
    if (req[0]) begin
      arb_grant = 3'b001;
      arb_hex   = hex0;
    end else if (req[1]) begin
      arb_grant = 3'b010;
      arb_hex   = hex1;
    end else if (req[2]) begin
      arb_grant = 3'b100;
      arb_hex   = hex2;
    end
    if (arb_grant != '0) begin
      for (int i = 0; i < 8; i++) begin
        arb_frame[8*i +: 8] = {~dp[i], glyph(arb_hex[4*i +: 4])};
      end
    end
  end

  assign bit_nxt = bit_q + BIT_W'(1);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    frame_d   = frame_q;
    bit_d     = bit_q;
    div_d     = div_q;
    seg_clk_d = 1'b0;
    sout_d    = sout_q;
    pen_d     = pen_q;
    pending_d = pending_q;

    if (start && (state_q != IDLE)) pending_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (start || pending_q) state_d = LOAD;
      end
      LOAD: begin
        state_d = SHIFT;
        sout_d  = frame_q[FRAME_W-1];
        bit_d   = '0;
        div_d   = '0;
      end
      SHIFT: begin
        seg_clk_d = seg_clk_q;
        if (div_q == DIV_LAST) begin
          div_d     = '0;
          seg_clk_d = ~seg_clk_q;
          // Next bit is presented on the falling edge; bit index 63-n is ~n in 6 bits
          if (seg_clk_q) begin
            if (bit_q == BIT_LAST) begin
              state_d = LATCH;
            end else begin
              bit_d  = bit_nxt;
              sout_d = frame_q[~bit_nxt];
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      LATCH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if ((state_q == IDLE) && (state_d == LOAD)) begin
      pending_d = 1'b0;
      grant_d   = arb_grant;
      frame_d   = arb_frame;
    end
    if (state_d == LATCH) pen_d = 1'b1;

    busy_d = (state_d == LOAD) || (state_d == SHIFT);
    done_d = (state_d == LATCH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      frame_q   <= '0;
      bit_q     <= '0;
      div_q     <= '0;
      seg_clk_q <= 1'b0;
      sout_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pen_q     <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      frame_q   <= frame_d;
      bit_q     <= bit_d;
      div_q     <= div_d;
      seg_clk_q <= seg_clk_d;
      sout_q    <= sout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pen_q     <= pen_d;
      pending_q <= pending_d;
    end
  end

  assign grant    = grant_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign seg_clk  = seg_clk_q;
  assign seg_sout = sout_q;
  assign SEG_PEN  = pen_q;
  // The clear line simply follows reset so it is high the instant reset releases
  assign seg_clrn = rst_n;

endmodule

// File: tb/tb_seg_disp_sched.sv
// Scoreboard bench for seg_disp_sched: expected frames are queued at start and
// compared against the bits captured on seg_clk rising edges when done pulses.
module tb_seg_disp_sched;

  localparam int unsigned DIV = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  req = '0;
  logic [31:0] hex0 = '0, hex1 = '0, hex2 = '0;
  logic [7:0]  dp = '0;
  logic [2:0]  grant;
  logic        busy, done, seg_clk, seg_clrn, seg_sout, SEG_PEN;

  always #5 clk = ~clk;

  seg_disp_sched #(.DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .req(req),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .dp(dp),
    .grant(grant), .busy(busy), .done(done), .seg_clk(seg_clk),
    .seg_clrn(seg_clrn), .seg_sout(seg_sout), .SEG_PEN(SEG_PEN)
  );

  int total = 0;
  int bad = 0;
  int nbits = 0;
  int run = 0;
  bit had_fall = 1'b0;
  logic prev_clk, prev_sout;
  logic [63:0] shreg = '0;
  logic [63:0] last_frame = '0;
  logic [63:0] expq[$];

  function automatic logic [7:0] glyph8(input logic [3:0] h);
    logic [7:0] t [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                           8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    return t[h];
  endfunction

  function automatic logic [63:0] model_frame(input logic [2:0] r, input logic [31:0] h0,
                                              input logic [31:0] h1, input logic [31:0] h2,
                                              input logic [7:0] d);
    logic [63:0] f;
    logic [31:0] h;
    logic [7:0]  g;
    if (r == 3'b000) return '1;
    h = r[0] ? h0 : (r[1] ? h1 : h2);
    for (int i = 0; i < 8; i++) begin
      g = glyph8(h[4*i +: 4]);
      f[8*i +: 8] = {~d[i], g[6:0]};
    end
    return f;
  endfunction

  // Per-cycle display-line checker and serial receiver
  always @(negedge clk) begin
    logic [63:0] e;
    if (!rst_n) begin
      nbits = 0;
      had_fall = 1'b0;
      run = 0;
    end else begin
      total++;
      if (seg_clk === 1'b1 && seg_sout !== prev_sout) begin
        bad++;
        $display("FAIL sout_stable t=%0t sout %b->%b while seg_clk high", $time, prev_sout, seg_sout);
      end
      if (seg_clk === prev_clk) begin
        run++;
      end else begin
        if (prev_clk === 1'b1 || had_fall) begin
          total++;
          if (run != DIV) begin
            bad++;
            $display("FAIL seg_clk_half t=%0t level=%b got %0d cycles, need %0d", $time, prev_clk, run, DIV);
          end
        end
        if (prev_clk === 1'b1) had_fall = 1'b1;
        else begin
          shreg = {shreg[62:0], seg_sout};
          nbits++;
        end
        run = 1;
      end
      if (done === 1'b1) begin
        total++;
        if (nbits != 64) begin
          bad++;
          $display("FAIL bit_count t=%0t got %0d bits, need 64", $time, nbits);
        end
        total++;
        if (expq.size() == 0) begin
          bad++;
          $display("FAIL scoreboard t=%0t got done with no expected frame queued", $time);
        end else begin
          e = expq.pop_front();
          if (shreg !== e) begin
            bad++;
            $display("FAIL frame t=%0t got %h, need %h", $time, shreg, e);
          end
        end
        last_frame = shreg;
        nbits = 0;
        had_fall = 1'b0;
      end
    end
    prev_clk = seg_clk;
    prev_sout = seg_sout;
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int n0, input int limit, output int n);
    n = n0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      n++;
      if (done === 1'b1) break;
      if (k == limit - 1) begin
        total++;
        bad++;
        $display("FAIL done_timeout t=%0t got no done after %0d cycles", $time, limit);
      end
    end
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (grant !== 3'b000) begin bad++; $display("FAIL rst_grant got %b need 000", grant); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got %b need 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got %b need 0", done); end
    total++; if (seg_clk !== 1'b0) begin bad++; $display("FAIL rst_seg_clk got %b need 0", seg_clk); end
    total++; if (seg_sout !== 1'b1) begin bad++; $display("FAIL rst_sout got %b need 1", seg_sout); end
    total++; if (SEG_PEN !== 1'b0) begin bad++; $display("FAIL rst_pen got %b need 0", SEG_PEN); end
    total++; if (seg_clrn !== 1'b0) begin bad++; $display("FAIL rst_clrn got %b need 0", seg_clrn); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (seg_clrn !== 1'b1) begin bad++; $display("FAIL clrn_after got %b need 1", seg_clrn); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got %b need 0", busy); end
  endtask

  task automatic test_basic();
    int n;
    req = 3'b001; hex0 = 32'h01234567; hex1 = 32'h55555555; dp = 8'h00;
    total++; if (SEG_PEN !== 1'b0) begin bad++; $display("FAIL pen_before got %b need 0", SEG_PEN); end
    expq.push_back(model_frame(req, hex0, hex1, hex2, dp));
    pulse_start();
    @(negedge clk);
    total++; if (grant !== 3'b001) begin bad++; $display("FAIL basic_grant got %b need 001", grant); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got %b need 1", busy); end
    wait_done(1, 600, n);
    total++; if (n != 258) begin bad++; $display("FAIL basic_latency got %0d need 258", n); end
    total++; if (SEG_PEN !== 1'b1) begin bad++; $display("FAIL pen_rise got %b need 1", SEG_PEN); end
    total++; if (last_frame[63:40] !== 24'hC0F9A4) begin bad++; $display("FAIL first_bytes got %h need c0f9a4", last_frame[63:40]); end
    @(negedge clk);
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL after_done got done=%b busy=%b need 0 0", done, busy); end
  endtask

  task automatic test_priority();
    int n;
    req = 3'b110; hex1 = 32'h89ABCDEF; hex2 = 32'hFEDC0BA9; dp = 8'hA5;
    expq.push_back(model_frame(req, hex0, hex1, hex2, dp));
    pulse_start();
    @(negedge clk);
    total++; if (grant !== 3'b010) begin bad++; $display("FAIL prio_grant got %b need 010", grant); end
    repeat (100) @(negedge clk);
    req = 3'b100; hex1 = 32'h00000000;
    repeat (5) @(negedge clk);
    total++; if (grant !== 3'b010) begin bad++; $display("FAIL prio_hold got %b need 010", grant); end
    wait_done(106, 600, n);
    total++; if (n != 258) begin bad++; $display("FAIL prio_latency got %0d need 258", n); end
    expq.push_back(model_frame(req, hex0, hex1, hex2, dp));
    pulse_start();
    @(negedge clk);
    total++; if (grant !== 3'b100) begin bad++; $display("FAIL prio_next got %b need 100", grant); end
    wait_done(1, 600, n);
  endtask

  task automatic test_blank();
    int n;
    req = 3'b000; dp = 8'hFF;
    expq.push_back(model_frame(req, hex0, hex1, hex2, dp));
    pulse_start();
    @(negedge clk);
    total++; if (grant !== 3'b000) begin bad++; $display("FAIL blank_grant got %b need 000", grant); end
    wait_done(1, 600, n);
    total++; if (last_frame !== 64'hFFFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL blank_frame got %h need all ones", last_frame); end
  endtask

  task automatic test_back_to_back();
    int n;
    int extra;
    req = 3'b001; hex0 = 32'hDEADBEEF; dp = 8'h0F;
    expq.push_back(model_frame(req, hex0, hex1, hex2, dp));
    expq.push_back(model_frame(req, hex0, hex1, hex2, dp));
    pulse_start();
    repeat (20) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      pulse_start();
      repeat (7) @(negedge clk);
    end
    wait_done(0, 600, n);
    wait_done(0, 600, n);
    total++; if (n != 259) begin bad++; $display("FAIL b2b_gap got %0d need 259", n); end
    extra = 0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    total++; if (extra != 0) begin bad++; $display("FAIL b2b_idle got %0d active cycles need 0", extra); end
  endtask

  task automatic test_latch_start();
    int n;
    req = 3'b010; hex1 = 32'h2468ACE0; dp = 8'h81;
    expq.push_back(model_frame(req, hex0, hex1, hex2, dp));
    expq.push_back(model_frame(req, hex0, hex1, hex2, dp));
    pulse_start();
    wait_done(0, 600, n);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(0, 600, n);
    total++; if (n != 259) begin bad++; $display("FAIL latch_start got %0d need 259", n); end
  endtask

  task automatic test_reset_mid();
    int n;
    int act;
    bit hit;
    req = 3'b001; hex0 = 32'h13579BDF; dp = 8'h3C;
    expq.push_back(model_frame(req, hex0, hex1, hex2, dp));
    pulse_start();
    hit = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk); #1;
      if (nbits >= 30) begin hit = 1'b1; break; end
    end
    total++; if (!hit) begin bad++; $display("FAIL mid_reach got %0d bits need 30", nbits); end
    rst_n = 1'b0;
    #1;
    total++; if (grant !== 3'b000 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL mid_rst_ctl got grant=%b busy=%b done=%b need 000 0 0", grant, busy, done);
    end
    total++; if (seg_clk !== 1'b0 || seg_sout !== 1'b1 || SEG_PEN !== 1'b0 || seg_clrn !== 1'b0) begin
      bad++; $display("FAIL mid_rst_seg got clk=%b sout=%b pen=%b clrn=%b need 0 1 0 0", seg_clk, seg_sout, SEG_PEN, seg_clrn);
    end
    expq.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    act = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) act++;
    end
    total++; if (act != 0) begin bad++; $display("FAIL mid_idle got %0d active cycles need 0", act); end
    expq.push_back(model_frame(req, hex0, hex1, hex2, dp));
    pulse_start();
    wait_done(0, 600, n);
    total++; if (n != 258) begin bad++; $display("FAIL mid_restart got %0d need 258", n); end
    total++; if (SEG_PEN !== 1'b1) begin bad++; $display("FAIL mid_pen got %b need 1", SEG_PEN); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t bench did not finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_blank();
    test_back_to_back();
    test_latch_start();
    test_reset_mid();
    repeat (5) @(negedge clk);
    total++; if (expq.size() != 0) begin bad++; $display("FAIL leftover got %0d frames need 0", expq.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
